// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART ALU receive path.
//   DATA_BITS_DEF / OP_BITS_DEF : default operand and opcode widths
//   OVERSAMPLE                  : s_tick pulses per bit time
//   TIMEOUT_TICKS_DEF           : default inter-byte timeout, 4 characters
//                                 of 10 bits (start + 8 data + stop)
//   frame_state_t               : command framer state encoding
package uart_alu_pkg;

  localparam int unsigned DATA_BITS_DEF     = 8;
  localparam int unsigned OP_BITS_DEF       = 6;
  localparam int unsigned OVERSAMPLE        = 16;
  localparam int unsigned CHAR_BITS         = 10;
  localparam int unsigned TIMEOUT_CHARS     = 4;
  localparam int unsigned TIMEOUT_TICKS_DEF = TIMEOUT_CHARS * CHAR_BITS * OVERSAMPLE;

  typedef enum logic [1:0] {
    WAIT_A  = 2'd0,
    WAIT_B  = 2'd1,
    WAIT_OP = 2'd2,
    HOLD    = 2'd3
  } frame_state_t;

endpackage

// File: rtl/tick_timeout_counter.sv
// Counts enable ticks since the last clear and flags the tick on which the
// allowed count is used up.
//   clk, reset : system clock, synchronous active-high reset
//   clr        : hold the count at zero
//   en         : count enable (16x baud tick)
//   expire     : combinational, high on the TIMEOUT_TICKS-th tick since clr;
//                never high when TIMEOUT_TICKS is 0
module tick_timeout_counter #(
  parameter int unsigned TIMEOUT_TICKS = 640
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned TW = (TIMEOUT_TICKS > 0) ? $clog2(TIMEOUT_TICKS + 1) : 1;
  localparam logic [TW-1:0] LAST = (TIMEOUT_TICKS > 0) ? TW'(TIMEOUT_TICKS - 1) : '0;

  logic [TW-1:0] r_count;

  assign expire = (TIMEOUT_TICKS != 0) && en && (r_count == LAST);

  // Restart on expiry so the count never runs past the limit.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= expire ? '0 : r_count + TW'(1);
    end
  end

endmodule

// File: rtl/alu_cmd_framer.sv
// Receive-side framer: assembles the A, B, OP bytes from the UART receiver
// into one command and offers it on a valid/ready handshake.
//   clk, reset        : system clock, synchronous active-high reset
//   s_tick            : 16x baud enable, drives the inter-byte timeout
//   rx_done_tick      : received-byte strobe, rx_data valid with it
//   rx_data           : received byte
//   cmd_valid         : command held for the consumer
//   cmd_ready         : consumer accepts (only looked at in HOLD)
//   cmd_a/cmd_b       : operands
//   cmd_op            : opcode, low OP_BITS of the third byte
//   timeout_err       : pulse when a partial frame is abandoned
//   overrun_err       : pulse when a byte arrives while a command is held
//   frame_state       : state encoding for LED debug
module alu_cmd_framer
  import uart_alu_pkg::*;
#(
  parameter int unsigned DATA_BITS     = DATA_BITS_DEF,
  parameter int unsigned OP_BITS       = OP_BITS_DEF,
  parameter int unsigned TIMEOUT_TICKS = TIMEOUT_TICKS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_tick,
  input  logic                 rx_done_tick,
  input  logic [DATA_BITS-1:0] rx_data,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [DATA_BITS-1:0] cmd_a,
  output logic [DATA_BITS-1:0] cmd_b,
  output logic [OP_BITS-1:0]   cmd_op,
  output logic                 timeout_err,
  output logic                 overrun_err,
  output logic [1:0]           frame_state
);

  frame_state_t r_state, w_next;

  logic w_expire, w_timer_clr;
  logic w_cap_a, w_cap_b, w_cap_op, w_timeout, w_overrun;

  logic                 r_cmd_valid;
  logic [DATA_BITS-1:0] r_cmd_a, r_cmd_b;
  logic [OP_BITS-1:0]   r_cmd_op;
  logic                 r_timeout_err, r_overrun_err;

  tick_timeout_counter #(
    .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .clr   (w_timer_clr),
    .en    (s_tick),
    .expire(w_expire)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= WAIT_A;
    else       r_state <= w_next;
  end

  // Next-state logic; a byte arriving on the expiring tick takes priority.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      WAIT_A:  if (rx_done_tick) w_next = WAIT_B;
      WAIT_B:  if (rx_done_tick) w_next = WAIT_OP;
               else if (w_expire) w_next = WAIT_A;
      WAIT_OP: if (rx_done_tick) w_next = HOLD;
               else if (w_expire) w_next = WAIT_A;
      HOLD:    if (cmd_ready)    w_next = rx_done_tick ? WAIT_B : WAIT_A;
      default: w_next = WAIT_A;
    endcase
  end

  // Output / strobe decode. The timer only runs mid-frame and restarts on
  // every accepted byte.
  always_comb begin
    w_timer_clr = 1'b1;
    w_cap_a     = 1'b0;
    w_cap_b     = 1'b0;
    w_cap_op    = 1'b0;
    w_timeout   = 1'b0;
    w_overrun   = 1'b0;
    unique case (r_state)
      WAIT_A: w_cap_a = rx_done_tick;
      WAIT_B: begin
        w_timer_clr = rx_done_tick;
        w_cap_b     = rx_done_tick;
        w_timeout   = w_expire && !rx_done_tick;
      end
      WAIT_OP: begin
        w_timer_clr = rx_done_tick;
        w_cap_op    = rx_done_tick;
        w_timeout   = w_expire && !rx_done_tick;
      end
      HOLD: begin
        w_cap_a   = rx_done_tick && cmd_ready;
        w_overrun = rx_done_tick && !cmd_ready;
      end
      default: ;
    endcase
  end

  // Capture registers and error pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cmd_valid   <= 1'b0;
      r_cmd_a       <= '0;
      r_cmd_b       <= '0;
      r_cmd_op      <= '0;
      r_timeout_err <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      r_cmd_valid   <= (w_next == HOLD);
      r_timeout_err <= w_timeout;
      r_overrun_err <= w_overrun;
      if (w_cap_a)  r_cmd_a  <= rx_data;
      if (w_cap_b)  r_cmd_b  <= rx_data;
      if (w_cap_op) r_cmd_op <= rx_data[OP_BITS-1:0];
    end
  end

  assign cmd_valid   = r_cmd_valid;
  assign cmd_a       = r_cmd_a;
  assign cmd_b       = r_cmd_b;
  assign cmd_op      = r_cmd_op;
  assign timeout_err = r_timeout_err;
  assign overrun_err = r_overrun_err;
  assign frame_state = r_state;

endmodule

// File: tb/tb_alu_cmd_framer.sv
module tb_alu_cmd_framer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_tick = 1'b0;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_data = '0;
  logic       cmd_ready = 1'b0;
  logic       cmd_valid;
  logic [7:0] cmd_a, cmd_b;
  logic [5:0] cmd_op;
  logic       timeout_err, overrun_err;
  logic [1:0] frame_state;

  int n_tests = 0;
  int n_fail  = 0;
  int n_to    = 0;
  int n_ov    = 0;
  int n_both  = 0;

  alu_cmd_framer #(
    .DATA_BITS(8),
    .OP_BITS(6),
    .TIMEOUT_TICKS(640)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .s_tick      (s_tick),
    .rx_done_tick(rx_done_tick),
    .rx_data     (rx_data),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .cmd_op      (cmd_op),
    .timeout_err (timeout_err),
    .overrun_err (overrun_err),
    .frame_state (frame_state)
  );

  always #5 clk = ~clk;

  // Error pulse bookkeeping, sampled away from the active edge.
  always @(negedge clk) begin
    if (timeout_err === 1'b1) n_to++;
    if (overrun_err === 1'b1) n_ov++;
    if (timeout_err === 1'b1 && overrun_err === 1'b1) n_both++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One-cycle byte strobe; returns at the negedge after the capturing edge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_done_tick = 1'b1;
    rx_data      = b;
    @(negedge clk);
    rx_done_tick = 1'b0;
  endtask

  // n consecutive s_tick cycles; returns at the negedge after the last one.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      s_tick = 1'b1;
    end
    @(negedge clk);
    s_tick = 1'b0;
  endtask

  task automatic check_cmd(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [5:0] op);
    check({tag, "_a"},  32'(cmd_a),  32'(a));
    check({tag, "_b"},  32'(cmd_b),  32'(b));
    check({tag, "_op"}, 32'(cmd_op), 32'(op));
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_valid", 32'(cmd_valid), 0);
    check_cmd("rst", 8'h00, 8'h00, 6'h00);
    check("rst_to",    32'(timeout_err), 0);
    check("rst_ov",    32'(overrun_err), 0);
    check("rst_state", 32'(frame_state), 0);

    // Normal frame with consumer ready
    cmd_ready = 1'b1;
    send_byte(8'h05);
    check("nrm_state_b", 32'(frame_state), 1);
    send_byte(8'h03);
    check("nrm_state_op", 32'(frame_state), 2);
    check("nrm_valid_pre", 32'(cmd_valid), 0);
    send_byte(8'h20);
    check("nrm_valid", 32'(cmd_valid), 1);
    check_cmd("nrm", 8'h05, 8'h03, 6'h20);
    @(negedge clk);
    check("nrm_valid_drop", 32'(cmd_valid), 0);
    check("nrm_state_a", 32'(frame_state), 0);
    check("nrm_no_err", 32'(n_to + n_ov), 0);

    // Timeout after a lone A byte
    send_byte(8'h11);
    tick(639);
    check("to_state_early", 32'(frame_state), 1);
    check("to_not_yet", 32'(n_to), 0);
    tick(1);
    check("to_pulse", 32'(timeout_err), 1);
    check("to_state", 32'(frame_state), 0);
    check("to_stale_a", 32'(cmd_a), 32'h11);
    @(negedge clk);
    check("to_pulse_end", 32'(timeout_err), 0);
    check("to_count", 32'(n_to), 1);
    send_byte(8'h07);
    send_byte(8'h02);
    send_byte(8'h22);
    check("to_new_valid", 32'(cmd_valid), 1);
    check_cmd("to_new", 8'h07, 8'h02, 6'h22);
    @(negedge clk);

    // Byte arriving on the expiring tick wins
    send_byte(8'h13);
    tick(639);
    @(negedge clk);
    s_tick       = 1'b1;
    rx_done_tick = 1'b1;
    rx_data      = 8'h09;
    @(negedge clk);
    s_tick       = 1'b0;
    rx_done_tick = 1'b0;
    check("race_state", 32'(frame_state), 2);
    check("race_b", 32'(cmd_b), 32'h09);
    check("race_no_to", 32'(timeout_err), 0);
    send_byte(8'h21);
    check("race_op", 32'(cmd_op), 32'h21);
    @(negedge clk);
    check("race_to_count", 32'(n_to), 1);

    // Backpressure: byte during HOLD is dropped
    cmd_ready = 1'b0;
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h20);
    check("bp_valid", 32'(cmd_valid), 1);
    send_byte(8'hAA);
    check("bp_ov", 32'(overrun_err), 1);
    check("bp_valid_held", 32'(cmd_valid), 1);
    check("bp_state", 32'(frame_state), 3);
    check_cmd("bp", 8'h01, 8'h02, 6'h20);
    @(negedge clk);
    check("bp_ov_end", 32'(overrun_err), 0);
    check("bp_ov_count", 32'(n_ov), 1);

    // Accept and new byte in the same cycle
    rx_done_tick = 1'b1;
    rx_data      = 8'h33;
    cmd_ready    = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
    cmd_ready    = 1'b0;
    check("sim_valid", 32'(cmd_valid), 0);
    check("sim_a", 32'(cmd_a), 32'h33);
    check("sim_state", 32'(frame_state), 1);
    check("sim_no_ov", 32'(overrun_err), 0);

    // Opcode masking on the continuing frame
    cmd_ready = 1'b1;
    send_byte(8'h34);
    send_byte(8'hE6);
    check("mask_valid", 32'(cmd_valid), 1);
    check_cmd("mask", 8'h33, 8'h34, 6'h26);
    @(negedge clk);
    check("mask_state", 32'(frame_state), 0);

    // Reset mid-frame
    send_byte(8'h44);
    send_byte(8'h55);
    check("mid_state", 32'(frame_state), 2);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mrst_valid", 32'(cmd_valid), 0);
    check_cmd("mrst", 8'h00, 8'h00, 6'h00);
    check("mrst_state", 32'(frame_state), 0);
    check("mrst_errs", 32'({timeout_err, overrun_err}), 0);
    send_byte(8'h0F);
    send_byte(8'h01);
    send_byte(8'h20);
    check("post_valid", 32'(cmd_valid), 1);
    check_cmd("post", 8'h0F, 8'h01, 6'h20);
    @(negedge clk);
    check("post_state", 32'(frame_state), 0);

    check("total_to", 32'(n_to), 1);
    check("total_ov", 32'(n_ov), 1);
    check("err_exclusive", 32'(n_both), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_cmd_framer.md
Name: alu_cmd_framer

Overview:
Sits between the UART receiver and the ALU control FSM, and is the receive-side front end of the UART ALU top.
- Assembles the three-byte command (A, B, OP) from the receiver's byte stream.
- Discards partial frames after an inter-byte timeout, counted in 16x baud ticks.
- Presents the completed command on a valid/ready handshake.
- Flags dropped bytes so the control FSM no longer tracks byte order itself.

Parameters:
DATA_BITS, 8, width of operands A and B and of rx_data.
OP_BITS, 6, width of the opcode field, taken from rx_data[OP_BITS-1:0].
TIMEOUT_TICKS, 640, s_tick count allowed between bytes of one frame (about 4 character times at 16x oversampling); 0 disables the timeout.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
s_tick  in  1  16x baud enable pulse from the baud generator
rx_done_tick  in  1  one-cycle pulse; rx_data is valid in the same cycle
rx_data  in  DATA_BITS  received byte
cmd_valid  out  1  complete command available
cmd_ready  in  1  consumer accepts the command
cmd_a  out  DATA_BITS  operand A
cmd_b  out  DATA_BITS  operand B
cmd_op  out  OP_BITS  opcode
timeout_err  out  1  one-cycle pulse when a partial frame is discarded
overrun_err  out  1  one-cycle pulse when a byte is dropped during HOLD
frame_state  out  2  current state encoding, for LED debug

Behaviour:
- Reset (synchronous, active-high; clock clk):
  - state goes to WAIT_A; timer = 0.
  - cmd_valid, cmd_a, cmd_b, cmd_op, timeout_err and overrun_err all = 0.
  - Reset mid-frame discards the partial frame with no error pulse.
- States: WAIT_A=0, WAIT_B=1, WAIT_OP=2, HOLD=3. frame_state outputs this encoding.
- WAIT_A: on rx_done_tick, cmd_a <= rx_data, timer <= 0, go to WAIT_B. The timer is idle in this state.
- WAIT_B: on rx_done_tick, cmd_b <= rx_data, timer <= 0, go to WAIT_OP.
- WAIT_OP: on rx_done_tick, cmd_op <= rx_data[OP_BITS-1:0], go to HOLD. Upper bits of rx_data are ignored.
- Timer behaviour in WAIT_B and WAIT_OP:
  - timer increments on each s_tick; width is $clog2(TIMEOUT_TICKS+1).
  - Timeout fires when s_tick is high, timer == TIMEOUT_TICKS-1, and rx_done_tick is low.
  - On timeout: go to WAIT_A, timer <= 0, timeout_err pulses for 1 cycle, and cmd_a/cmd_b keep their stale values.
  - If rx_done_tick and the timeout condition occur in the same cycle, the byte wins: no timeout, normal capture.
- HOLD:
  - cmd_valid = 1 is registered, rising the cycle after the OP byte's rx_done_tick (latency 1 cycle).
  - cmd_a, cmd_b and cmd_op are stable while cmd_valid=1.
  - cmd_ready=1: transfer completes; next cycle cmd_valid=0 and state is WAIT_A.
  - rx_done_tick with cmd_ready=0: the byte is dropped, overrun_err pulses for 1 cycle, and the state stays HOLD.
  - rx_done_tick with cmd_ready=1 in the same cycle: transfer completes, the byte is captured as the new cmd_a, and the next state is WAIT_B with cmd_valid=0. No error.
- cmd_ready is ignored outside HOLD.
- The error pulses never assert together and are never asserted in reset.

Decomposition:
- Package uart_alu_pkg holds:
  - DATA_BITS and OP_BITS defaults;
  - the frame_state encodings WAIT_A/WAIT_B/WAIT_OP/HOLD;
  - the OVERSAMPLE=16 constant used to derive TIMEOUT_TICKS.
- One natural sub-module, tick_timeout_counter, with:
  - inputs clr, en (= s_tick) and the TIMEOUT_TICKS parameter;
  - output expire, a combinational compare.
- The FSM and capture registers stay in alu_cmd_framer.

Test Plan:
- Normal frame: bytes 0x05, 0x03, 0x20, cmd_ready held 1 -> cmd_valid high exactly 1 cycle after the third rx_done_tick, with cmd_a=0x05, cmd_b=0x03, cmd_op=0x20; back to WAIT_A; no error pulses.
- Timeout: send 0x11, then nothing for 640 s_ticks -> timeout_err pulses once and frame_state returns to 0. Then 0x07, 0x02, 0x22 -> cmd_a=0x07, cmd_b=0x02, cmd_op=0x22.
- Race: in WAIT_B, assert rx_done_tick (0x09) on the same cycle as the 640th s_tick -> no timeout_err; cmd_b=0x09; state WAIT_OP.
- Backpressure: complete frame 0x01, 0x02, 0x20 with cmd_ready=0, then send 0xAA -> overrun_err pulses once; cmd_a, cmd_b and cmd_op stay 0x01/0x02/0x20; cmd_valid stays 1.
- Simultaneous: in HOLD, assert cmd_ready and rx_done_tick (0x33) together -> cmd_valid drops next cycle, cmd_a=0x33, frame_state=1, no overrun_err.
- Reset mid-frame: after 0x44 and 0x55, assert reset for 1 cycle -> all outputs 0 and frame_state=0. A new frame 0x0F, 0x01, 0x20 then decodes cleanly.
- Opcode masking: OP byte 0xE6 -> cmd_op=0x26.
